// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control package: FSM state encoding, default syscall service
// codes and a saturating-increment helper for the performance counters.
package cpu_ctrl_pkg;

  // Hold-controller states.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Syscall service code that never halts the CPU.
  localparam logic [31:0] DEF_PASS_CODE = 32'h0000_0022;
  // Syscall service code that terminates the program.
  localparam logic [31:0] DEF_EXIT_CODE = 32'h0000_000A;
  // Default depth of the Go synchronizer.
  localparam int DEF_SYNC_STAGES = 2;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/go_edge_sync.sv
// Go pushbutton synchronizer and rising-edge detector.
// Go passes through SYNC_STAGES flops; Go_rise pulses for one cycle when the
// synchronized level goes 0->1. A press that is already held when reset is
// released does not count: the detector only arms after it has observed a
// genuine low level once the synchronizer has refilled with post-reset samples.
module go_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Go,
  output logic Go_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_dly;
  logic                   r_armed;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer chain; Go is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Go};
    end
  end

  // Tracks when every synchronizer stage holds a sample taken after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else begin
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // One-cycle delayed copy of the synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly <= 1'b0;
    end else begin
      r_dly <= w_sync;
    end
  end

  // Arm once a real post-reset low level has been seen at the chain output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (r_fill[SYNC_STAGES-1] && !w_sync) begin
      r_armed <= 1'b1;
    end
  end

  assign Go_rise = w_sync & ~r_dly & r_armed;

endmodule

// File: rtl/pc_hold_ctrl.sv
// PC hold controller: stalls the PC on load-use conflicts, halts on non-pass
// syscalls until a Go press, and stops permanently on the exit syscall.
// Optional performance counters are built only when PC_HOLD_PERF_CNT_EN is
// defined; otherwise the counter outputs are constant zero.
module pc_hold_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] PASS_CODE   = DEF_PASS_CODE,
  parameter logic [31:0] EXIT_CODE   = DEF_EXIT_CODE,
  parameter int          SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Syscall,
  input  logic [31:0] R1_out,
  input  logic        Go,
  input  logic        Conflict,
  output logic        PC_en,
  output logic        Flush,
  output logic        Halted,
  output logic        Done,
  output logic [31:0] Cycle_cnt,
  output logic [31:0] Stall_cnt,
  output logic [31:0] Halt_cnt
);

  state_t r_state;
  logic   w_go_rise;
  logic   w_stop_req;
  logic   w_is_exit;
  logic   w_pc_en;
  logic   w_flush;

  go_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_go_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .Go     (Go),
    .Go_rise(w_go_rise)
  );

  // A syscall that is not the pass code stops the PC (halt or exit).
  assign w_stop_req = Syscall & (R1_out != PASS_CODE);
  assign w_is_exit  = (R1_out == EXIT_CODE);

  // Zero-latency PC enable and bubble insertion from state and inputs.
  always_comb begin
    w_pc_en = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      RUN: begin
        w_pc_en = ~Conflict & ~w_stop_req;
        w_flush = Conflict;
      end
      HALT: begin
        w_pc_en = w_go_rise;
      end
      default: begin
        w_pc_en = 1'b0;
        w_flush = 1'b0;
      end
    endcase
  end

  // Outputs are held low for the whole time reset is asserted.
  assign PC_en = rst_n & w_pc_en;
  assign Flush = rst_n & w_flush;

  // Control FSM; a conflict freezes the state even when a syscall is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (!Conflict && w_stop_req) begin
            r_state <= w_is_exit ? DONE : HALT;
          end
        end
        HALT: begin
          if (w_go_rise) begin
            r_state <= RUN;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign Halted = (r_state == HALT);
  assign Done   = (r_state == DONE);

`ifdef PC_HOLD_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_halt_cnt;
  logic        w_enter_halt;

  assign w_enter_halt = (r_state == RUN) & ~Conflict & w_stop_req & ~w_is_exit;

  // Active-cycle counter; frozen once the program has exited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (r_state != DONE) begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
    end
  end

  // Load-use stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && Conflict) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  // Counts entries into HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt_cnt <= '0;
    end else if (w_enter_halt) begin
      r_halt_cnt <= sat_inc(r_halt_cnt);
    end
  end

  assign Cycle_cnt = r_cycle_cnt;
  assign Stall_cnt = r_stall_cnt;
  assign Halt_cnt  = r_halt_cnt;
`else
  assign Cycle_cnt = '0;
  assign Stall_cnt = '0;
  assign Halt_cnt  = '0;
`endif

endmodule

// File: tb/tb_pc_hold_ctrl.sv
// Self-checking bench for pc_hold_ctrl with a behavioural reference model.
module tb_pc_hold_ctrl;

  localparam int          SYNC = 2;
  localparam logic [31:0] PASS = 32'h0000_0022;
  localparam logic [31:0] EXIT = 32'h0000_000A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Syscall = 1'b0;
  logic [31:0] R1_out = '0;
  logic        Go = 1'b0;
  logic        Conflict = 1'b0;
  logic        PC_en, Flush, Halted, Done;
  logic [31:0] Cycle_cnt, Stall_cnt, Halt_cnt;

  int errors = 0;
  int checks = 0;

  pc_hold_ctrl #(.PASS_CODE(PASS), .EXIT_CODE(EXIT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .Syscall(Syscall), .R1_out(R1_out), .Go(Go),
    .Conflict(Conflict), .PC_en(PC_en), .Flush(Flush), .Halted(Halted),
    .Done(Done), .Cycle_cnt(Cycle_cnt), .Stall_cnt(Stall_cnt), .Halt_cnt(Halt_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_state: 0 running, 1 halted, 2 done
  int          m_state;
  logic [31:0] m_cyc, m_stall, m_halt;
  bit          q[$];   // Go level sampled at every clock edge since reset

  function automatic void m_reset();
    m_state = 0; m_cyc = 0; m_stall = 0; m_halt = 0;
    q.delete();
  endfunction

  // A press is seen SYNC edges after it is first sampled, and only if a low
  // sample preceded it after reset.
  function automatic bit m_rise();
    int n;
    n = q.size();
    if (n < SYNC + 1) return 1'b0;
    return (q[n-SYNC] == 1'b1) && (q[n-SYNC-1] == 1'b0);
  endfunction

  function automatic logic [3:0] m_outs();
    logic pe, fl;
    pe = 1'b0; fl = 1'b0;
    if (m_state == 0) begin
      pe = !Conflict && !(Syscall && (R1_out != PASS));
      fl = Conflict;
    end else if (m_state == 1) begin
      pe = m_rise();
    end
    return {pe, fl, m_state == 1, m_state == 2};
  endfunction

  function automatic logic [95:0] m_cnts();
`ifdef PC_HOLD_PERF_CNT_EN
    return {m_cyc, m_stall, m_halt};
`else
    return '0;
`endif
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit r;
    @(posedge clk);
    r = m_rise();
    if (m_state != 2) m_cyc = sat1(m_cyc);
    case (m_state)
      0: begin
        if (Conflict) m_stall = sat1(m_stall);
        else if (Syscall && R1_out != PASS) begin
          if (R1_out == EXIT) m_state = 2;
          else begin m_state = 1; m_halt = sat1(m_halt); end
        end
      end
      1: if (r) m_state = 0;
      default: ;
    endcase
    q.push_back(Go);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Conflict = 0; Syscall = 0; Go = 0; R1_out = 0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk); #1;
    checks++;
    if ({PC_en, Flush} !== 2'b00) begin
      errors++; $display("FAIL reset_outs_forced act=%b exp=00", {PC_en, Flush});
    end
    Conflict = 1; #1;
    checks++;
    if ({PC_en, Flush} !== 2'b00) begin
      errors++; $display("FAIL reset_flush_forced act=%b exp=00", {PC_en, Flush});
    end
    Conflict = 0;
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if ({Halted, Done, Cycle_cnt, Stall_cnt, Halt_cnt} !== 98'd0) begin
      errors++; $display("FAIL reset_state act=%b%b cnt=%h/%h/%h exp=0", Halted, Done, Cycle_cnt, Stall_cnt, Halt_cnt);
    end
    checks++;
    if (m_outs() !== {PC_en, Flush, Halted, Done}) begin
      errors++; $display("FAIL reset_run_outs act=%b exp=%b", {PC_en, Flush, Halted, Done}, m_outs());
    end
    tick();
  endtask

  task automatic test_pass_syscall();
    do_reset();
    Syscall = 1; R1_out = PASS;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (PC_en !== 1'b1 || m_outs() !== {PC_en, Flush, Halted, Done}) begin
        errors++; $display("FAIL pass_syscall act=%b exp=%b", {PC_en, Flush, Halted, Done}, m_outs());
      end
      tick();
    end
    Syscall = 0; #1;
    checks++;
    if (Halted !== 1'b0 || Halt_cnt !== 32'd0 || {Cycle_cnt, Stall_cnt, Halt_cnt} !== m_cnts()) begin
      errors++; $display("FAIL pass_after act=%b cnt=%h/%h/%h exp=%h", Halted, Cycle_cnt, Stall_cnt, Halt_cnt, m_cnts());
    end
  endtask

  task automatic test_stall();
    do_reset();
    Conflict = 1; Syscall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({PC_en, Flush, Halted} !== 3'b010) begin
        errors++; $display("FAIL stall_cycle act=%b exp=010", {PC_en, Flush, Halted});
      end
      tick();
    end
    Conflict = 0; #1;
    checks++;
    if ({Cycle_cnt, Stall_cnt, Halt_cnt} !== m_cnts()) begin
      errors++; $display("FAIL stall_counts act=%h/%h/%h exp=%h", Cycle_cnt, Stall_cnt, Halt_cnt, m_cnts());
    end
`ifdef PC_HOLD_PERF_CNT_EN
    checks++;
    if (Stall_cnt !== 32'd3) begin
      errors++; $display("FAIL stall_cnt3 act=%0d exp=3", Stall_cnt);
    end
`endif
  endtask

  task automatic test_halt_resume();
    int pulses, pidx;
    do_reset();
    tick(); tick();
    Syscall = 1; R1_out = 32'h1; #1;
    checks++;
    if (PC_en !== 1'b0) begin
      errors++; $display("FAIL halt_req_pcen act=%b exp=0", PC_en);
    end
    tick();
    Syscall = 0; Go = 1;
    pulses = 0; pidx = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (m_outs() !== {PC_en, Flush, Halted, Done} || (i == 0 && Halted !== 1'b1)) begin
        errors++; $display("FAIL halt_go_cycle%0d act=%b exp=%b", i, {PC_en, Flush, Halted, Done}, m_outs());
      end
      if (PC_en && Halted) begin pulses++; pidx = i; end
      tick();
    end
    #1;
    checks++;
    if (pulses !== 1 || pidx !== SYNC || Halted !== 1'b0) begin
      errors++; $display("FAIL halt_resume_pulse act=%0d@%0d halted=%b exp=1@%0d", pulses, pidx, Halted, SYNC);
    end
    checks++;
    if ({Cycle_cnt, Stall_cnt, Halt_cnt} !== m_cnts()) begin
      errors++; $display("FAIL halt_counts act=%h/%h/%h exp=%h", Cycle_cnt, Stall_cnt, Halt_cnt, m_cnts());
    end
    // Halt again while Go is still held: no resume until a new press.
    Syscall = 1; R1_out = 32'h5;
    tick();
    Syscall = 0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (PC_en && Halted) pulses++;
      tick();
    end
    Go = 0; tick(); tick(); tick();
    Go = 1;
    for (int i = 0; i < 5; i++) begin
      #1; if (PC_en && Halted) pulses++;
      tick();
    end
    Go = 0; #1;
    checks++;
    if (pulses !== 1 || Halted !== 1'b0) begin
      errors++; $display("FAIL halt_repress act=%0d halted=%b exp=1 0", pulses, Halted);
    end
  endtask

  task automatic test_exit();
    do_reset();
    tick();
    Syscall = 1; R1_out = EXIT;
    tick();
    Syscall = 0; #1;
    checks++;
    if ({Done, Halted, PC_en} !== 3'b100) begin
      errors++; $display("FAIL exit_done act=%b exp=100", {Done, Halted, PC_en});
    end
    for (int i = 0; i < 20; i++) begin
      Go = ($urandom_range(0, 2) == 0) ? ~Go : Go;
      Conflict = ~Conflict;
      Syscall = $urandom_range(0, 1);
      R1_out = ($urandom_range(0, 1) == 0) ? PASS : 32'h1;
      #1;
      checks++;
      if (PC_en !== 1'b0 || Flush !== 1'b0 || Done !== 1'b1 ||
          {Cycle_cnt, Stall_cnt, Halt_cnt} !== m_cnts()) begin
        errors++; $display("FAIL exit_frozen i=%0d act=%b%b%b cyc=%h exp=001 %h", i, PC_en, Flush, Done, Cycle_cnt, m_cnts());
      end
      tick();
    end
    Go = 0; Conflict = 0; Syscall = 0;
  endtask

  task automatic test_conflict_priority();
    do_reset();
    Conflict = 1; Syscall = 1; R1_out = 32'h1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({PC_en, Flush, Halted} !== 3'b010) begin
        errors++; $display("FAIL prio_conflict act=%b exp=010", {PC_en, Flush, Halted});
      end
      tick();
    end
    Conflict = 0; #1;
    checks++;
    if ({PC_en, Flush, Halted} !== 3'b000) begin
      errors++; $display("FAIL prio_release act=%b exp=000", {PC_en, Flush, Halted});
    end
    tick();
    Syscall = 0; #1;
    checks++;
    if (Halted !== 1'b1 || {Cycle_cnt, Stall_cnt, Halt_cnt} !== m_cnts()) begin
      errors++; $display("FAIL prio_halt act=%b cnt=%h/%h/%h exp=1 %h", Halted, Cycle_cnt, Stall_cnt, Halt_cnt, m_cnts());
    end
  endtask

  task automatic test_reset_in_halt();
    int pulses;
    do_reset();
    tick(); tick();
    Syscall = 1; R1_out = 32'h1;
    tick();
    Syscall = 0; Go = 1;
    tick();
    rst_n = 1'b0;
    m_reset(); #1;
    checks++;
    if ({PC_en, Flush, Halted} !== 3'b000) begin
      errors++; $display("FAIL rsthalt_during act=%b exp=000", {PC_en, Flush, Halted});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if ({Halted, Done, Cycle_cnt, Stall_cnt, Halt_cnt} !== 98'd0) begin
      errors++; $display("FAIL rsthalt_state act=%b%b cnt=%h/%h/%h exp=0", Halted, Done, Cycle_cnt, Stall_cnt, Halt_cnt);
    end
    Syscall = 1; R1_out = 32'h7;
    tick();
    Syscall = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_outs() !== {PC_en, Flush, Halted, Done}) begin
        errors++; $display("FAIL rsthalt_held%0d act=%b exp=%b", i, {PC_en, Flush, Halted, Done}, m_outs());
      end
      if (PC_en && Halted) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0 || Halted !== 1'b1) begin
      errors++; $display("FAIL rsthalt_nopulse act=%0d halted=%b exp=0 1", pulses, Halted);
    end
    Go = 0; tick(); tick(); tick();
    Go = 1;
    for (int i = 0; i < 4; i++) begin
      #1; if (PC_en && Halted) pulses++;
      tick();
    end
    Go = 0; #1;
    checks++;
    if (pulses !== 1 || Halted !== 1'b0) begin
      errors++; $display("FAIL rsthalt_resume act=%0d halted=%b exp=1 0", pulses, Halted);
    end
  endtask

  task automatic test_random();
    int done_cycles;
    do_reset();
    done_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      Conflict = ($urandom_range(0, 3) == 0);
      Syscall  = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: R1_out = PASS;
        4:          R1_out = ($urandom_range(0, 5) == 0) ? EXIT : 32'h1;
        5, 6:       R1_out = 32'h1;
        default:    R1_out = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) Go = ~Go;
      #1;
      checks++;
      if (m_outs() !== {PC_en, Flush, Halted, Done}) begin
        errors++; $display("FAIL rand_outs i=%0d act=%b exp=%b", i, {PC_en, Flush, Halted, Done}, m_outs());
      end
      checks++;
      if ({Cycle_cnt, Stall_cnt, Halt_cnt} !== m_cnts()) begin
        errors++; $display("FAIL rand_cnts i=%0d act=%h/%h/%h exp=%h", i, Cycle_cnt, Stall_cnt, Halt_cnt, m_cnts());
      end
      tick();
      done_cycles = (m_state == 2) ? done_cycles + 1 : 0;
      if (done_cycles > 4) begin
        do_reset();
        done_cycles = 0;
      end
    end
    Conflict = 0; Syscall = 0; Go = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_pass_syscall();
    test_stall();
    test_halt_resume();
    test_exit();
    test_conflict_priority();
    test_reset_in_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_hold_ctrl.md
PC_HOLD_CTRL -- requirements
Module: pc_hold_ctrl

Interface
REQ-001 SHALL have parameter PASS_CODE, default 32'h00000022: syscall service code that never halts the CPU.
REQ-002 SHALL have parameter EXIT_CODE, default 32'h0000000A: syscall service code that terminates the program.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on Go (minimum 2).
REQ-004 SHALL use one clock, `clk`, and an asynchronous, active-low reset, `rst_n`.
REQ-005 SHALL have the following ports, in this order:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Syscall  input  1  the current instruction is a syscall.
- R1_out  input  32  register $v0 value, the syscall service code.
- Go  input  1  asynchronous resume pushbutton.
- Conflict  input  1  load-use hazard from the datapath.
- PC_en  output  1  PC write enable.
- Flush  output  1  insert a bubble this cycle.
- Halted  output  1  FSM is in HALT.
- Done  output  1  FSM is in DONE.
- Cycle_cnt  output  32  performance counter.
- Stall_cnt  output  32  performance counter.
- Halt_cnt  output  32  performance counter.

Function
REQ-006 SHALL implement an FSM with three states: RUN, HALT and DONE.
REQ-007 RUN: PC_en SHALL equal ~Conflict & ~(Syscall & R1_out!=PASS_CODE).
REQ-008 RUN: Flush SHALL equal Conflict.
REQ-009 RUN with Conflict=1: the state SHALL NOT change, regardless of Syscall. Conflict has priority.
REQ-010 RUN, Conflict=0, Syscall=1, R1_out==EXIT_CODE: the next state SHALL be DONE.
REQ-011 RUN, Conflict=0, Syscall=1, R1_out not equal to PASS_CODE or EXIT_CODE: the next state SHALL be HALT.
REQ-012 RUN, Syscall=1, R1_out==PASS_CODE: the state SHALL stay RUN and the PC SHALL advance normally.
REQ-013 HALT: PC_en SHALL be 0 and Flush SHALL be 0, except in a Go_rise cycle, where PC_en=1 and the next state is RUN.
REQ-014 Go_rise SHALL equal the SYNC_STAGES-synchronized Go AND NOT its one-cycle-delayed copy, giving one pulse per press.
REQ-015 Go_rise in RUN or DONE SHALL be ignored.
REQ-016 DONE: PC_en=0 and Flush=0 until reset; DONE is terminal.
REQ-017 Halted SHALL equal (state==HALT) and Done SHALL equal (state==DONE); both are decoded directly from the state register.
REQ-018 PC_en and Flush are combinational from the state and inputs; latency SHALL be 0 cycles for Conflict and Syscall.
REQ-019 Go-to-PC_en latency SHALL be SYNC_STAGES rising edges after Go is first sampled high.
REQ-020 Go held high for any length SHALL yield exactly one PC_en pulse.
REQ-021 Go released and pressed again SHALL yield a new pulse only if the FSM is in HALT.

Reset
REQ-022 rst_n=0 SHALL asynchronously set the state to RUN and clear the synchronizer flops, the delay flop and all counters.
REQ-023 While rst_n=0, PC_en and Flush SHALL be forced to 0.
REQ-024 Deassertion of rst_n while Go is held high SHALL NOT generate Go_rise.
REQ-025 Reset asserted during HALT or DONE SHALL return the FSM to RUN, with no PC_en pulse.

Configuration
REQ-026 With macro PC_HOLD_PERF_CNT_EN defined, the counters SHALL behave as follows:
- Cycle_cnt increments every cycle in RUN or HALT and freezes in DONE.
- Stall_cnt increments each RUN cycle with Conflict=1.
- Halt_cnt increments on each RUN-to-HALT transition.
- All counters saturate at 32'hFFFFFFFF.
REQ-027 Without PC_HOLD_PERF_CNT_EN, Cycle_cnt, Stall_cnt and Halt_cnt SHALL be tied to 0 and no counter flops SHALL be synthesized.

Structure
REQ-028 A shared package, cpu_ctrl_pkg, SHALL hold the state enum (RUN, HALT, DONE) and the default PASS/EXIT code constants.
REQ-029 The synchronizer and edge detector SHALL be a sub-module, go_edge_sync, with ports clk, rst_n, Go, Go_rise and parameter SYNC_STAGES.

Verification
REQ-030 Bench SHALL cover the normal syscall and load-use stall:
- Syscall=1 with R1_out=0x22 in RUN -> PC_en=1, state stays RUN, Halt_cnt stays 0.
- Conflict=1 for 3 cycles in RUN -> PC_en=0 and Flush=1 for 3 cycles, Stall_cnt=3.
REQ-031 Bench SHALL cover halt and resume: Syscall=1 with R1_out=0x01 -> Halted=1 next cycle. Then Go held high for 10 cycles -> exactly one PC_en=1 cycle 2 edges after sampling, then RUN, Halt_cnt=1.
REQ-032 Bench SHALL cover exit: Syscall=1 with R1_out=0x0A -> Done=1. After that, Go pulses and Conflict toggles -> PC_en stays 0 and Cycle_cnt is frozen.
REQ-033 Bench SHALL cover simultaneous hazard and syscall: Conflict=1 and Syscall=1 (R1_out=0x01) together -> no HALT entry. When Conflict drops to 0 -> HALT entry.
REQ-034 Bench SHALL cover reset in HALT: rst_n pulsed low mid-HALT with Go held high -> RUN, all counters 0, no PC_en pulse from the held Go.
